// File: rtl/hc595_ctrl.sv
// hc595_ctrl: continuously serialises the 7-segment drive {sel, seg} into a
// 74HC595 chain, one 14-bit frame at a time, ending each frame with a
// storage latch so the displayed pattern changes atomically.
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   sel[5:0]   digit select, 1 = digit enabled
//   seg[7:0]   segment pattern, active-low, seg[7] = dp
//   ds         serial data to 595 DS
//   shcp       595 shift clock (data sampled on its rising edge)
//   stcp       595 storage clock (latches on its rising edge)
//   oe         595 output enable, active-low
//
// CLK_DIV = sys_clk cycles per shifted bit (even, 2..256).
module hc595_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [5:0] sel,
   input  logic [7:0] seg,
   output logic       ds,
   output logic       shcp,
   output logic       stcp,
   output logic       oe
);

   localparam int unsigned DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SW    = 4;
   localparam int unsigned NBITS = 14;

   localparam logic [DW-1:0] D_MAX  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);
   localparam logic [SW-1:0] S_LAST = SW'(NBITS);

   logic [DW-1:0]    d_q, d_nxt;
   logic [SW-1:0]    s_q, s_nxt;
   logic [NBITS-1:0] frame_q, frame_nxt;
   logic             run_q;
   logic [SW-1:0]    slot_prev;
   logic             late_half;
   logic             ds_nxt, shcp_nxt, stcp_nxt, oe_nxt;

   // Next-state and output decode. Outputs registered at an edge describe the
   // position one cycle behind the counters, so the decode looks at the
   // previous (slot, divider) position. run_q masks the very first edge after
   // reset, where no previous position exists (prevents a spurious latch).
   always_comb begin
      d_nxt     = d_q + DW'(1);
      s_nxt     = s_q;
      frame_nxt = frame_q;
      slot_prev = s_q;
      late_half = (d_q > D_HALF);
      ds_nxt    = 1'b0;
      shcp_nxt  = 1'b0;
      stcp_nxt  = 1'b0;
      oe_nxt    = oe;

      if (d_q == D_MAX) begin
         d_nxt = '0;
         s_nxt = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      end

      // Snapshot in shift order: seg LSB first, then sel MSB first.
      if (s_q == '0 && d_q == '0)
         frame_nxt = {sel[0], sel[1], sel[2], sel[3], sel[4], sel[5], seg};

      // Previous divider value was D-1, always in the late half of the bit.
      if (d_q == '0) begin
         slot_prev = (s_q == '0) ? S_LAST : s_q - SW'(1);
         late_half = 1'b1;
      end

      if (run_q) begin
         if (slot_prev == S_LAST) begin
            stcp_nxt = late_half;
         end else begin
            ds_nxt   = frame_q[slot_prev];
            shcp_nxt = late_half;
         end
      end

      // Enable the display once the first latch pulse has completed.
      if (stcp && !stcp_nxt)
         oe_nxt = 1'b0;
   end

   // State and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         d_q     <= '0;
         s_q     <= '0;
         frame_q <= '0;
         run_q   <= 1'b0;
         ds      <= 1'b0;
         shcp    <= 1'b0;
         stcp    <= 1'b0;
         oe      <= 1'b1;
      end else begin
         d_q     <= d_nxt;
         s_q     <= s_nxt;
         frame_q <= frame_nxt;
         run_q   <= 1'b1;
         ds      <= ds_nxt;
         shcp    <= shcp_nxt;
         stcp    <= stcp_nxt;
         oe      <= oe_nxt;
      end
   end

endmodule
